// File: rtl/ioctl_ram_arbiter.sv
// ioctl_ram_arbiter
// Shares one single-port synchronous main RAM between the Z80 CPU bus and the
// HPS ioctl download stream. One ioctl byte is buffered and the host is
// throttled with ioctl_wait. The CPU is held in reset for the duration of a
// download whose index matches DL_INDEX.
//
// Ports
//   clk_48_i            system clock, rising edge
//   reset_n_i           asynchronous active-low reset
//   ioctl_download_i    host download active
//   ioctl_index_i [8]   download target index
//   ioctl_wr_i          one-cycle byte strobe
//   ioctl_addr_i  [25]  byte address within the image
//   ioctl_dout_i  [8]   byte data
//   ioctl_wait_o        host must not strobe while high (buffer full)
//   cpu_req_i           CPU request, held until cpu_ack_o
//   cpu_we_i            1 = write, 0 = read
//   cpu_addr_i    [AW]  CPU byte address
//   cpu_wdata_i   [8]   CPU write data
//   cpu_rdata_o   [8]   read data, valid in the cpu_ack_o cycle
//   cpu_ack_o           one-cycle access-complete pulse
//   cpu_hold_o          CPU reset request during a matching download
//   ram_ce_o            RAM cycle enable
//   ram_we_o            RAM write enable (qualifies ram_ce_o)
//   ram_addr_o    [AW]  RAM address (holds when idle)
//   ram_wdata_o   [8]   RAM write data (holds when idle)
//   ram_rdata_i   [8]   RAM read data
//   dl_done_o           one-cycle pulse at end of an accepted download
//   dl_overrun_o        sticky: strobe seen while the buffer was full

module ioctl_ram_arbiter #(
    parameter int unsigned AW       = 16,
    parameter int unsigned RAM_LAT  = 1,
    parameter logic [7:0]  DL_INDEX = 8'h00,
    parameter int unsigned DL_BASE  = 0
) (
    input  logic          clk_48_i,
    input  logic          reset_n_i,
    input  logic          ioctl_download_i,
    input  logic [7:0]    ioctl_index_i,
    input  logic          ioctl_wr_i,
    input  logic [24:0]   ioctl_addr_i,
    input  logic [7:0]    ioctl_dout_i,
    output logic          ioctl_wait_o,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [7:0]    cpu_wdata_i,
    output logic [7:0]    cpu_rdata_o,
    output logic          cpu_ack_o,
    output logic          cpu_hold_o,
    output logic          ram_ce_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [7:0]    ram_wdata_o,
    input  logic [7:0]    ram_rdata_i,
    output logic          dl_done_o,
    output logic          dl_overrun_o
);

    localparam int unsigned TW = 26;
    localparam int unsigned CW = 2;
    localparam logic [CW-1:0] LAT_LAST = CW'(RAM_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DL_WR  = 2'd1,
        ST_CPU_RD = 2'd2,
        ST_CPU_WR = 2'd3
    } state_e;

    state_e          state_q,     state_d;
    logic [CW-1:0]   lat_cnt_q,   lat_cnt_d;
    logic            buf_full_q,  buf_full_d;
    logic [AW-1:0]   buf_addr_q,  buf_addr_d;
    logic [7:0]      buf_data_q,  buf_data_d;
    logic            overrun_q,   overrun_d;
    logic            dl_prev_q;
    logic            hold_q,      hold_d;
    logic            done_q,      done_d;
    logic            ram_ce_q,    ram_ce_d;
    logic            ram_we_q,    ram_we_d;
    logic [AW-1:0]   ram_addr_q,  ram_addr_d;
    logic [7:0]      ram_wdata_q, ram_wdata_d;
    logic            ack_q,       ack_d;
    logic [7:0]      rdata_q,     rdata_d;

    logic            dl_match;
    logic [TW-1:0]   dl_target;
    logic            dl_in_range;
    logic            dl_accept;
    logic            dl_overrun_hit;

    // Download strobe qualification and RAM target computation
    always_comb begin
        dl_match       = ioctl_download_i && (ioctl_index_i == DL_INDEX);
        dl_target      = TW'(ioctl_addr_i) + TW'(DL_BASE);
        dl_in_range    = ((dl_target >> AW) == '0);
        dl_accept      = ioctl_wr_i && dl_match && !buf_full_q && dl_in_range;
        dl_overrun_hit = ioctl_wr_i && dl_match && buf_full_q;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        buf_full_d  = buf_full_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        overrun_d   = overrun_q;
        hold_d      = hold_q;
        done_d      = 1'b0;
        ram_ce_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ack_d       = 1'b0;
        rdata_d     = rdata_q;

        if (dl_accept) begin
            buf_full_d = 1'b1;
            buf_addr_d = AW'(dl_target);
            buf_data_d = ioctl_dout_i;
        end
        if (dl_overrun_hit) begin
            overrun_d = 1'b1;
        end

        // Hold is released only once the last buffered byte has drained
        if (dl_match && !dl_prev_q) begin
            hold_d = 1'b1;
        end else if (hold_q && !ioctl_download_i && !buf_full_q) begin
            hold_d = 1'b0;
            done_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (buf_full_q) begin
                    state_d     = ST_DL_WR;
                    ram_ce_d    = 1'b1;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = buf_addr_q;
                    ram_wdata_d = buf_data_q;
                // A byte landing this cycle gets the next slot; the ack
                // cycle of the previous access is never reused
                end else if (cpu_req_i && !dl_accept && !ack_q) begin
                    ram_ce_d   = 1'b1;
                    ram_addr_d = cpu_addr_i;
                    if (cpu_we_i) begin
                        state_d     = ST_CPU_WR;
                        ram_we_d    = 1'b1;
                        ram_wdata_d = cpu_wdata_i;
                        ack_d       = 1'b1;
                    end else begin
                        state_d   = ST_CPU_RD;
                        lat_cnt_d = '0;
                    end
                end
            end
            ST_DL_WR: begin
                buf_full_d = 1'b0;
                state_d    = ST_IDLE;
            end
            ST_CPU_RD: begin
                if (lat_cnt_q == LAT_LAST) begin
                    rdata_d = ram_rdata_i;
                    ack_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q + CW'(1);
                end
            end
            ST_CPU_WR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_48_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            lat_cnt_q   <= '0;
            buf_full_q  <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            overrun_q   <= 1'b0;
            dl_prev_q   <= 1'b0;
            hold_q      <= 1'b0;
            done_q      <= 1'b0;
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            buf_full_q  <= buf_full_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            overrun_q   <= overrun_d;
            dl_prev_q   <= ioctl_download_i;
            hold_q      <= hold_d;
            done_q      <= done_d;
            ram_ce_q    <= ram_ce_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
        end
    end

    assign ioctl_wait_o = buf_full_q;
    assign cpu_rdata_o  = rdata_q;
    assign cpu_ack_o    = ack_q;
    assign cpu_hold_o   = hold_q;
    assign ram_ce_o     = ram_ce_q;
    assign ram_we_o     = ram_we_q;
    assign ram_addr_o   = ram_addr_q;
    assign ram_wdata_o  = ram_wdata_q;
    assign dl_done_o    = done_q;
    assign dl_overrun_o = overrun_q;

endmodule

// File: tb/tb_ioctl_ram_arbiter.sv
// Bench for ioctl_ram_arbiter: directed timing scenarios followed by a
// randomized concurrent download + CPU phase checked against a shadow memory.

module tb_ioctl_ram_arbiter;

    localparam int unsigned AW      = 16;
    localparam int unsigned RAM_LAT = 2;

    logic          clk_48 = 1'b0;
    logic          reset_n;
    logic          ioctl_download;
    logic [7:0]    ioctl_index;
    logic          ioctl_wr;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          ioctl_wait;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic [7:0]    cpu_rdata;
    logic          cpu_ack;
    logic          cpu_hold;
    logic          ram_ce;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;
    logic          dl_done;
    logic          dl_overrun;

    int n_checks  = 0;
    int n_fail    = 0;
    int n_ram_wr  = 0;
    int exp_wr    = 0;
    bit host_done = 1'b0;

    logic [7:0]    mem     [0:65535];
    logic [7:0]    ref_mem [0:65535];
    logic [15:0]   dl_hist [$];

    always #5 clk_48 = ~clk_48;

    ioctl_ram_arbiter #(
        .AW       (AW),
        .RAM_LAT  (RAM_LAT),
        .DL_INDEX (8'h00),
        .DL_BASE  (0)
    ) dut (
        .clk_48_i         (clk_48),
        .reset_n_i        (reset_n),
        .ioctl_download_i (ioctl_download),
        .ioctl_index_i    (ioctl_index),
        .ioctl_wr_i       (ioctl_wr),
        .ioctl_addr_i     (ioctl_addr),
        .ioctl_dout_i     (ioctl_dout),
        .ioctl_wait_o     (ioctl_wait),
        .cpu_req_i        (cpu_req),
        .cpu_we_i         (cpu_we),
        .cpu_addr_i       (cpu_addr),
        .cpu_wdata_i      (cpu_wdata),
        .cpu_rdata_o      (cpu_rdata),
        .cpu_ack_o        (cpu_ack),
        .cpu_hold_o       (cpu_hold),
        .ram_ce_o         (ram_ce),
        .ram_we_o         (ram_we),
        .ram_addr_o       (ram_addr),
        .ram_wdata_o      (ram_wdata),
        .ram_rdata_i      (ram_rdata),
        .dl_done_o        (dl_done),
        .dl_overrun_o     (dl_overrun)
    );

    // RAM macro: read data valid one clock after the ce cycle, so the
    // second cycle of a RAM_LAT=2 access sees it
    always @(posedge clk_48) begin
        if (ram_ce) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Every RAM write must carry the byte the shadow memory says belongs there
    always @(posedge clk_48) begin
        if (reset_n && ram_ce && ram_we) begin
            n_ram_wr++;
            check("ram_wr_data", 64'(ram_wdata), 64'(ref_mem[ram_addr]));
        end
    end

    task automatic step();
        @(posedge clk_48);
        #1;
    endtask

    // Host strobe issued only while ioctl_wait is low; shadow updated when
    // the byte is one the arbiter must accept
    task automatic dl_strobe(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        if (ioctl_download && ioctl_index == 8'h00 && a < 25'h10000) begin
            ref_mem[a[15:0]] = d;
            exp_wr++;
            dl_hist.push_back(a[15:0]);
        end
        step();
        ioctl_wr = 1'b0;
    endtask

    task automatic cpu_access(input logic we, input logic [15:0] a, input logic [7:0] wd,
                              output logic [7:0] rd, output bit ok);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        ok = 1'b0;
        rd = '0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (cpu_ack) begin
                ok = 1'b1;
                rd = cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        if (ok && we) begin
            ref_mem[a] = wd;
            exp_wr++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        bit         ok;
        bit         seen;
        logic [15:0] a16;

        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        reset_n = 1'b0;
        ioctl_download = 1'b0; ioctl_index = 8'h00; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

        // Reset values
        step(); step(); step();
        check("rst_wait",    64'(ioctl_wait), 64'd0);
        check("rst_ack",     64'(cpu_ack),    64'd0);
        check("rst_rdata",   64'(cpu_rdata),  64'd0);
        check("rst_hold",    64'(cpu_hold),   64'd0);
        check("rst_ce_we",   64'({ram_ce, ram_we}), 64'd0);
        check("rst_addr",    64'({ram_addr, ram_wdata}), 64'd0);
        check("rst_done_ov", 64'({dl_done, dl_overrun}), 64'd0);
        reset_n = 1'b1;
        step();
        check("post_rst_wait", 64'(ioctl_wait), 64'd0);

        // Single download byte
        ioctl_download = 1'b1;
        step();
        check("hold_set", 64'(cpu_hold), 64'd1);
        dl_strobe(25'h0010, 8'hA5);
        check("t2_wait_next", 64'(ioctl_wait), 64'd1);
        check("t2_no_ce_yet", 64'(ram_ce), 64'd0);
        step();
        check("t2_ram_wr", 64'({ram_ce, ram_we, ram_addr, ram_wdata}), {38'd0, 2'b11, 16'h0010, 8'hA5});
        check("t2_wait_during", 64'(ioctl_wait), 64'd1);
        step();
        check("t2_wait_clear", 64'(ioctl_wait), 64'd0);
        check("t2_ce_clear", 64'(ram_ce), 64'd0);

        // CPU read, RAM_LAT = 2
        mem[16'h1234] = 8'h5A; ref_mem[16'h1234] = 8'h5A;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
        step();
        check("t3_rd_ce", 64'({ram_ce, ram_we, ram_addr}), {46'd0, 2'b10, 16'h1234});
        check("t3_no_ack1", 64'(cpu_ack), 64'd0);
        step();
        check("t3_ce_single", 64'(ram_ce), 64'd0);
        check("t3_no_ack2", 64'(cpu_ack), 64'd0);
        step();
        check("t3_ack", 64'(cpu_ack), 64'd1);
        check("t3_rdata", 64'(cpu_rdata), 64'h5A);
        cpu_req = 1'b0;
        step();
        check("t3_ack_pulse", 64'(cpu_ack), 64'd0);

        // Simultaneous download strobe and CPU write: download goes first
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 8'h77;
        dl_strobe(25'h0020, 8'h3C);
        check("t4_cpu_deferred", 64'({ram_ce, cpu_ack}), 64'd0);
        step();
        check("t4_dl_first", 64'({ram_ce, ram_we, ram_addr, ram_wdata}), {38'd0, 2'b11, 16'h0020, 8'h3C});
        step();
        check("t4_gap", 64'({ram_ce, ioctl_wait}), 64'd0);
        ref_mem[16'h0040] = 8'h77;
        exp_wr++;
        step();
        check("t4_cpu_wr", 64'({ram_ce, ram_we, ram_addr, ram_wdata}), {38'd0, 2'b11, 16'h0040, 8'h77});
        check("t4_cpu_ack", 64'(cpu_ack), 64'd1);
        cpu_req = 1'b0;
        step();

        // Strobe while full: dropped, overrun sticky
        dl_strobe(25'h0030, 8'h11);
        check("t5_wait", 64'(ioctl_wait), 64'd1);
        ioctl_wr = 1'b1; ioctl_addr = 25'h0031; ioctl_dout = 8'h22;
        step();
        ioctl_wr = 1'b0;
        check("t5_overrun", 64'(dl_overrun), 64'd1);
        check("t5_first_byte", 64'({ram_ce, ram_addr, ram_wdata}), {39'd0, 1'b1, 16'h0030, 8'h11});
        step(); step();
        check("t5_overrun_sticky", 64'(dl_overrun), 64'd1);

        // Target beyond RAM: dropped, no wait
        ioctl_wr = 1'b1; ioctl_addr = 25'h10005; ioctl_dout = 8'h44;
        step();
        ioctl_wr = 1'b0;
        check("oor_no_wait", 64'(ioctl_wait), 64'd0);
        step();
        check("oor_no_ce", 64'(ram_ce), 64'd0);

        // Download ends with buffer full
        dl_strobe(25'h0050, 8'h99);
        ioctl_download = 1'b0;
        check("t6_wait", 64'({ioctl_wait, cpu_hold}), 64'b11);
        step();
        check("t6_drain", 64'({ram_ce, ram_addr, cpu_hold}), {46'd0, 1'b1, 16'h0050, 1'b1});
        step();
        check("t6_hold_still", 64'({cpu_hold, dl_done}), 64'b10);
        step();
        check("t6_hold_clear_done", 64'({cpu_hold, dl_done}), 64'b01);
        step();
        check("t6_done_pulse", 64'(dl_done), 64'd0);

        // Non-matching index: no hold, no writes, no done
        ioctl_index = 8'h01; ioctl_download = 1'b1;
        step();
        check("idx1_no_hold", 64'(cpu_hold), 64'd0);
        ioctl_wr = 1'b1; ioctl_addr = 25'h0060; ioctl_dout = 8'hEE;
        step();
        ioctl_wr = 1'b0;
        check("idx1_no_wait", 64'(ioctl_wait), 64'd0);
        step();
        check("idx1_no_ce", 64'(ram_ce), 64'd0);
        ioctl_download = 1'b0;
        step(); step();
        check("idx1_no_done", 64'(dl_done), 64'd0);
        ioctl_index = 8'h00;

        // Async reset mid-download drops wait/hold immediately
        ioctl_download = 1'b1;
        step();
        ioctl_wr = 1'b1; ioctl_addr = 25'h0070; ioctl_dout = 8'h12;
        step();
        ioctl_wr = 1'b0;
        check("mid_rst_wait_pre", 64'(ioctl_wait), 64'd1);
        #2;
        reset_n = 1'b0;
        ioctl_download = 1'b0;
        #1;
        check("mid_rst_drop", 64'({ioctl_wait, cpu_hold, dl_overrun}), 64'd0);
        step(); step();
        reset_n = 1'b1;
        step();
        check("mid_rst_idle", 64'({ram_ce, ioctl_wait}), 64'd0);

        // Randomized concurrent phase
        dl_hist.delete();
        ioctl_download = 1'b1;
        fork
            begin
                for (int c = 0; c < 400; c++) begin
                    if (!ioctl_wait && ($urandom % 3) == 0) begin
                        if (($urandom % 8) == 0)
                            dl_strobe(25'h10000 + 25'($urandom_range(0, 16'hFFFF)), 8'($urandom));
                        else
                            dl_strobe(25'($urandom_range(16'h8000, 16'hFFFF)), 8'($urandom));
                    end else begin
                        step();
                    end
                end
                host_done = 1'b1;
            end
            begin
                for (int n = 0; n < 1000 && !host_done; n++) begin
                    a16 = 16'($urandom_range(0, 16'h7FFF));
                    if (($urandom % 2) == 0) begin
                        cpu_access(1'b1, a16, 8'($urandom), rd, ok);
                        check("rnd_wr_ack", 64'(ok), 64'd1);
                    end else begin
                        cpu_access(1'b0, a16, 8'h00, rd, ok);
                        check("rnd_rd_ack", 64'(ok), 64'd1);
                        check("rnd_rd_data", 64'(rd), 64'(ref_mem[a16]));
                    end
                    if (($urandom % 2) == 0) step();
                end
            end
        join

        ioctl_download = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step();
            if (dl_done) seen = 1'b1;
        end
        check("rnd_dl_done", 64'(seen), 64'd1);
        check("rnd_hold_off", 64'(cpu_hold), 64'd0);

        // Read back downloaded bytes through the CPU port
        for (int k = 0; k < 6 && dl_hist.size() > 0; k++) begin
            a16 = dl_hist.pop_back();
            cpu_access(1'b0, a16, 8'h00, rd, ok);
            check("rb_ack", 64'(ok), 64'd1);
            check("rb_data", 64'(rd), 64'(ref_mem[a16]));
            step();
        end

        step(); step(); step();
        check("ram_wr_count", 64'(n_ram_wr), 64'(exp_wr));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
